// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: divides clk_i into pixel strobes and
// walks an H_TOTAL x V_TOTAL raster, presenting registered per-pixel timing flags.
package vga_timing_pkg;
    typedef struct packed {
        logic valid;
        logic blank_n;
        logic hsync_n;
        logic vsync_n;
        logic end_of_line;
        logic end_of_frame;
    } VGA_Timing;
endpackage

module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned CLK_DIV   = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    output vga_timing_pkg::VGA_Timing timing_o,
    output logic [10:0]               x_o,
    output logic [9:0]                y_o,
    output logic [15:0]               frame_cnt_o
);

    localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW           = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned VW           = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam logic [2:0]  DIV_LAST     = 3'(CLK_DIV - 1);

    generate
        if (H_VISIBLE == 0) begin : g_bad_h_visible
            $error("vga_timing_gen: H_VISIBLE must be nonzero");
        end
        if (V_VISIBLE == 0) begin : g_bad_v_visible
            $error("vga_timing_gen: V_VISIBLE must be nonzero");
        end
        if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_bad_clk_div
            $error("vga_timing_gen: CLK_DIV must be in 1..8");
        end
        if (H_TOTAL > 2048) begin : g_bad_h_total
            $error("vga_timing_gen: H_TOTAL does not fit in x_o");
        end
        if (V_TOTAL > 1024) begin : g_bad_v_total
            $error("vga_timing_gen: V_TOTAL does not fit in y_o");
        end
    endgenerate

    logic [2:0]    div_cnt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    logic [31:0] h_pos;
    logic [31:0] v_pos;
    logic        strobe;
    logic        h_last;
    logic        v_last;
    logic        blank_n_d;
    logic        hsync_n_d;
    logic        vsync_n_d;

    // Decode in 32-bit space so range ends equal to the total never overflow.
    always_comb begin
        h_pos     = 32'(h_cnt);
        v_pos     = 32'(v_cnt);
        strobe    = en_i && (div_cnt == '0);
        h_last    = (h_pos == H_TOTAL - 1);
        v_last    = (v_pos == V_TOTAL - 1);
        blank_n_d = (h_pos < H_VISIBLE) && (v_pos < V_VISIBLE);
        hsync_n_d = !((h_pos >= H_SYNC_START) && (h_pos < H_SYNC_END));
        vsync_n_d = !((v_pos >= V_SYNC_START) && (v_pos < V_SYNC_END));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt               <= '0;
            h_cnt                 <= '0;
            v_cnt                 <= '0;
            timing_o.valid        <= 1'b0;
            timing_o.blank_n      <= 1'b0;
            timing_o.hsync_n      <= 1'b1;
            timing_o.vsync_n      <= 1'b1;
            timing_o.end_of_line  <= 1'b0;
            timing_o.end_of_frame <= 1'b0;
            x_o                   <= '0;
            y_o                   <= '0;
            frame_cnt_o           <= '0;
        end else begin
            timing_o.valid        <= strobe;
            timing_o.end_of_line  <= strobe && h_last;
            timing_o.end_of_frame <= strobe && h_last && v_last;

            if (en_i) begin
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 3'd1;
            end

            if (strobe) begin
                timing_o.blank_n <= blank_n_d;
                timing_o.hsync_n <= hsync_n_d;
                timing_o.vsync_n <= vsync_n_d;
                x_o              <= 11'(h_cnt);
                y_o              <= 10'(v_cnt);
                if (h_last) begin
                    h_cnt <= '0;
                    if (v_last) begin
                        v_cnt       <= '0;
                        frame_cnt_o <= frame_cnt_o + 16'd1;
                    end else begin
                        v_cnt <= v_cnt + VW'(1);
                    end
                end else begin
                    h_cnt <= h_cnt + HW'(1);
                end
            end
        end
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Free-running raster timing generator producing the VGA_Timing struct consumed by the video controller and the output stage.
- Counts pixel strobes across horizontal and vertical periods and drives per-pixel valid, blanking, sync and end-of-line/end-of-frame pulses, all registered.
- Sits directly upstream of the video controller's timing_i.
- Also exports the current raster position and a frame counter for CPU-visible status.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 1, clk_i cycles per pixel strobe (1..8)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- en_i  in  1  run enable; 0 freezes raster position
- timing_o  out  VGA_Timing  fields: valid, blank_n, hsync_n, vsync_n, end_of_line, end_of_frame
- x_o  out  11  horizontal pixel index of the strobe currently presented on timing_o
- y_o  out  10  line index of the strobe currently presented on timing_o
- frame_cnt_o  out  16  completed-frame counter, wraps modulo 2^16

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (rst_i). All outputs are registered.
- Totals:
  - H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK
  - V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK
- Internal state:
  - div_cnt in 0..CLK_DIV-1
  - h_cnt in 0..H_TOTAL-1
  - v_cnt in 0..V_TOTAL-1
- Reset values:
  - Internal: div_cnt=0, h_cnt=0, v_cnt=0.
  - timing_o: valid=0, blank_n=0, hsync_n=1, vsync_n=1, end_of_line=0, end_of_frame=0.
  - x_o=0, y_o=0, frame_cnt_o=0.
- Strobe: a clock with en_i=1 and div_cnt==0. On a strobe edge, outputs load from the current (h_cnt, v_cnt):
  - valid=1
  - x_o=h_cnt, y_o=v_cnt
  - blank_n = (h_cnt<H_VISIBLE && v_cnt<V_VISIBLE)
  - hsync_n = !(h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC))
  - vsync_n = !(v_cnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC))
  - end_of_line = (h_cnt==H_TOTAL-1)
  - end_of_frame = (h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1)
- Advance on the same strobe edge:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps from V_TOTAL-1 to 0; frame_cnt_o increments on that wrap.
- Non-strobe edges:
  - valid, end_of_line and end_of_frame are 0.
  - blank_n, hsync_n, vsync_n, x_o and y_o hold their last values.
- Pulse widths: end_of_line and end_of_frame are single-clock pulses, only ever coincident with valid=1. end_of_frame implies end_of_line in the same cycle.
- Divider:
  - With en_i=1, div_cnt increments and wraps at CLK_DIV-1.
  - With CLK_DIV=1, every enabled clock is a strobe.
- en_i=0: div_cnt, h_cnt, v_cnt and frame_cnt_o freeze; valid, end_of_line and end_of_frame are 0; the other outputs hold. Resume continues from the frozen position with no skipped or repeated strobes.
- Latency: first strobe edge after rst_i deasserts (with en_i=1) presents (0,0): valid=1, blank_n=1.
- Reset mid-frame: on the next edge, all state and outputs take reset values and the raster restarts at (0,0). No end_of_frame pulse is emitted for the aborted frame.
- Widths: counters are sized by $clog2 of the totals. x_o and y_o are zero-extended to 11 and 10 bits.
- Parameter legality: totals must fit in x_o and y_o. Elaboration fails on zero H_VISIBLE or V_VISIBLE, or on CLK_DIV outside 1..8.

Test Plan:
- Reset values: rst_i=1 for 3 clocks, then release with en_i=1 and default params. During reset: valid=0, hsync_n=1, vsync_n=1. First post-reset edge: valid=1, x_o=0, y_o=0, blank_n=1.
- Horizontal timing at defaults: hsync_n=0 for exactly 96 strobes, starting at x_o=656. blank_n=0 from x_o=640 to 799. end_of_line pulses at x_o=799, once per 800 strobes.
- Vertical and frame timing at defaults: vsync_n=0 on lines 490-491 only. end_of_frame asserts once per 420000 strobes, at (799,524), together with end_of_line. frame_cnt_o goes 0 to 1 on that edge.
- CLK_DIV=2 with small params (H 4/1/1/1, V 2/1/1/1): valid toggles every clock. end_of_line appears every 14 clocks; end_of_frame every 70 clocks.
- en_i pause: drop en_i for 5 clocks at x_o=100. Response: no valid pulses during the pause, outputs hold, next strobe shows x_o=101, and line period grows by exactly 5 clocks.
- Mid-frame reset: assert rst_i at (x=300, y=200) for 1 clock. Next edge: reset values. Following edge: x_o=0, y_o=0, frame_cnt_o unchanged at 0, no end_of_frame seen.
